// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_TX between a 1-byte port (A) and a 2-byte port (B).
// Latency: request sampled in IDLE -> ack next edge -> DATA_VALID pulse the edge after (2 cycles).
// Backpressure: requests are held until ack; grants wait for tx_busy low; bytes paced off tx_busy.
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    a_req,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ack,
    input  logic                    b_req,
    input  logic [2*DATA_WIDTH-1:0] b_data,
    output logic                    b_ack,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    tx_data_valid,
    input  logic                    tx_busy,
    output logic                    sched_busy,
    output logic                    frame_done,
    output logic                    err_timeout
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t                  state, state_nx;
    logic [2*DATA_WIDTH-1:0] buf_q, buf_nx;
    logic [1:0]              left_q, left_nx;
    logic [7:0]              cnt_q, cnt_nx;
    logic                    last_b_q, last_b_nx;   // 1: last grant went to port B
    logic                    grant_b;
    logic                    a_ack_nx, b_ack_nx, valid_nx, done_nx, err_nx, sbusy_nx;
    logic [DATA_WIDTH-1:0]   p_data_nx;

    // Register state and every output; reset leaves last grant at B so A wins the first tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            buf_q         <= '0;
            left_q        <= '0;
            cnt_q         <= '0;
            last_b_q      <= 1'b1;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            sched_busy    <= 1'b0;
            frame_done    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_nx;
            buf_q         <= buf_nx;
            left_q        <= left_nx;
            cnt_q         <= cnt_nx;
            last_b_q      <= last_b_nx;
            a_ack         <= a_ack_nx;
            b_ack         <= b_ack_nx;
            tx_p_data     <= p_data_nx;
            tx_data_valid <= valid_nx;
            sched_busy    <= sbusy_nx;
            frame_done    <= done_nx;
            err_timeout   <= err_nx;
        end
    end

    // Next-state logic: arbitrate in IDLE, emit a byte in SEND, pace on tx_busy rise then fall.
    always_comb begin
        state_nx  = state;
        buf_nx    = buf_q;
        left_nx   = left_q;
        cnt_nx    = cnt_q;
        last_b_nx = last_b_q;
        grant_b   = 1'b0;
        a_ack_nx  = 1'b0;
        b_ack_nx  = 1'b0;
        valid_nx  = 1'b0;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        p_data_nx = tx_p_data;
        case (state)
            IDLE: begin
                if (!tx_busy && (a_req || b_req)) begin
                    // B wins when alone, or on a tie when A was served last.
                    grant_b  = b_req && (!a_req || !last_b_q);
                    state_nx = SEND;
                    if (grant_b) begin
                        b_ack_nx  = 1'b1;
                        buf_nx    = b_data;
                        left_nx   = 2'd2;
                        last_b_nx = 1'b1;
                    end else begin
                        a_ack_nx  = 1'b1;
                        buf_nx    = {{DATA_WIDTH{1'b0}}, a_data};
                        left_nx   = 2'd1;
                        last_b_nx = 1'b0;
                    end
                end
            end
            SEND: begin
                valid_nx  = 1'b1;
                p_data_nx = buf_q[DATA_WIDTH-1:0];
                cnt_nx    = '0;
                state_nx  = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nx = WAIT_LO;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // UART never accepted the byte: drop whatever is left of the frame.
                    err_nx   = 1'b1;
                    left_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_q + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    left_nx = left_q - 2'd1;
                    if (left_q == 2'd2) begin
                        buf_nx   = {{DATA_WIDTH{1'b0}}, buf_q[2*DATA_WIDTH-1:DATA_WIDTH]};
                        state_nx = SEND;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        sbusy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed vectors, a UART_TX busy model, and a frame-level predictor.
// Latency: predictor works in edge timestamps; outputs compared every cycle on the falling edge.
// Backpressure: UART model raises busy 2 cycles after each valid and holds it 11 cycles.
module tb_uart_tx_sched;

    localparam int TO   = 16;
    localparam int UDLY = 2;
    localparam int ULEN = 11;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [7:0]  a_data = '0;
    logic [15:0] b_data = '0;
    logic        a_ack, b_ack, tx_data_valid, sched_busy, frame_done, err_timeout;
    logic [7:0]  tx_p_data;
    logic        tx_busy;
    logic        uart_busy = 1'b0, force_busy = 1'b0, uart_dead = 1'b0;

    assign tx_busy = uart_busy | force_busy;

    uart_tx_sched #(.DATA_WIDTH(8), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
        .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
        .sched_busy(sched_busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0;
    int cyc = 0;

    // Frame-level predictor state
    bit         m_busy = 0, m_last_b = 1, seen_hi = 0, prev_busy = 0;
    logic [7:0] mq[$];
    int         send_at = -1, valid_at = 0;
    logic       e_aack = 0, e_back = 0, e_valid = 0, e_done = 0, e_err = 0, e_sbusy = 0;
    logic [7:0] e_pdata = '0;

    // Logs for the hand-computed checks
    logic [7:0] vbytes[$];
    int         vcyc[$], fall_q[$], acks[$];
    int         done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;

    // Predictor: decides each edge's outputs from the frame rules and timestamps.
    always @(posedge CLK) begin
        int n;
        n = cyc + 1;
        e_aack = 0; e_back = 0; e_valid = 0; e_done = 0; e_err = 0;
        if (RST) begin
            m_busy = 0; mq.delete(); send_at = -1; m_last_b = 1; e_pdata = '0;
        end else if (!m_busy) begin
            if (!tx_busy && (a_req || b_req)) begin
                mq.delete();
                if (b_req && (!a_req || !m_last_b)) begin
                    e_back = 1; mq.push_back(b_data[7:0]); mq.push_back(b_data[15:8]); m_last_b = 1;
                end else begin
                    e_aack = 1; mq.push_back(a_data); m_last_b = 0;
                end
                m_busy = 1; send_at = n + 1;
            end
        end else if (send_at == n) begin
            e_valid = 1; e_pdata = mq.pop_front(); valid_at = n; seen_hi = 0; send_at = -1;
        end else if (!seen_hi) begin
            if (tx_busy) seen_hi = 1;
            else if (n - valid_at == TO) begin e_err = 1; m_busy = 0; mq.delete(); end
        end else if (!tx_busy) begin
            if (mq.size() > 0) send_at = n + 1;
            else begin e_done = 1; m_busy = 0; end
        end
        e_sbusy = m_busy;
        if (!tx_busy && prev_busy) fall_q.push_back(cyc);
        prev_busy = tx_busy;
        cyc = n;
    end

    // Compare every cycle and log events.
    always @(negedge CLK) begin
        if (cyc > 0) begin
            tests++;
            if ({a_ack, b_ack, tx_data_valid, frame_done, err_timeout, sched_busy} !==
                {e_aack, e_back, e_valid, e_done, e_err, e_sbusy} || tx_p_data !== e_pdata) begin
                fails++;
                $display("FAIL cycle_cmp @%0d: got ack_a,ack_b,vld,done,err,sbusy=%b%b%b%b%b%b pdata=%h, need %b%b%b%b%b%b pdata=%h",
                         cyc, a_ack, b_ack, tx_data_valid, frame_done, err_timeout, sched_busy, tx_p_data,
                         e_aack, e_back, e_valid, e_done, e_err, e_sbusy, e_pdata);
            end
            if (tx_data_valid) begin vbytes.push_back(tx_p_data); vcyc.push_back(cyc); end
            if (a_ack) acks.push_back(0);
            if (b_ack) acks.push_back(1);
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
            if (err_timeout) begin err_cnt++; err_cyc = cyc; end
        end
    end

    // UART_TX stand-in: busy 2 cycles after a valid, for 11 cycles.
    int ucnt = -1;
    always begin
        @(negedge CLK); #2;
        if (RST) begin
            ucnt = -1; uart_busy = 1'b0;
        end else begin
            if (tx_data_valid && !uart_dead) ucnt = 0;
            else if (ucnt >= 0) ucnt++;
            if (ucnt == UDLY) uart_busy = 1'b1;
            if (ucnt == UDLY + ULEN) begin uart_busy = 1'b0; ucnt = -1; end
        end
    end

    task automatic tick();
        @(negedge CLK); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    task automatic req_a(input logic [7:0] d);
        a_data = d; a_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (a_ack) begin a_req = 1'b0; return; end
        end
        a_req = 1'b0;
        chk("a_ack_timeout", 0, 1);
    endtask

    task automatic req_b(input logic [15:0] d);
        b_data = d; b_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (b_ack) begin b_req = 1'b0; return; end
        end
        b_req = 1'b0;
        chk("b_ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!sched_busy && !tx_busy) begin tick(); return; end
        end
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int k, f, r, nd, ne;
        // Reset state
        repeat (3) tick();
        chk("rst_sched_busy", int'(sched_busy), 0);
        chk("rst_p_data", int'(tx_p_data), 0);
        chk("rst_valid", int'(tx_data_valid), 0);
        chk("rst_acks", int'({a_ack, b_ack, frame_done, err_timeout}), 0);
        RST = 1'b0;

        // Tie from reset: A, then B, then A, B again
        fork req_a(8'h11); req_b(16'hBBAA); join
        wait_idle();
        fork req_a(8'h22); req_b(16'hDDCC); join
        wait_idle();
        chk("rr_count", acks.size(), 4);
        if (acks.size() == 4) begin
            chk("rr_0_A", acks[0], 0); chk("rr_1_B", acks[1], 1);
            chk("rr_2_A", acks[2], 0); chk("rr_3_B", acks[3], 1);
        end
        chk("rr_bytes", vbytes.size(), 6);
        if (vbytes.size() == 6) begin
            chk("rr_b1_lo", int'(vbytes[1]), 'hAA); chk("rr_b1_hi", int'(vbytes[2]), 'hBB);
        end

        // Single A frame
        k = vbytes.size(); nd = done_cnt; r = cyc;
        req_a(8'hA5);
        f = fall_q.size();
        wait_idle();
        chk("a_nbytes", vbytes.size() - k, 1);
        if (vbytes.size() > k) begin
            chk("a_byte", int'(vbytes[k]), 'hA5);
            chk("a_latency", vcyc[k] - r, 2);
        end
        chk("a_done_cnt", done_cnt - nd, 1);
        if (fall_q.size() > f) chk("a_done_after_fall", done_cyc - fall_q[f], 1);

        // Two-byte B frame
        k = vbytes.size(); nd = done_cnt;
        req_b(16'h1234);
        f = fall_q.size();
        wait_idle();
        chk("b_nbytes", vbytes.size() - k, 2);
        if (vbytes.size() == k + 2 && fall_q.size() >= f + 2) begin
            chk("b_lo", int'(vbytes[k]), 'h34);
            chk("b_hi", int'(vbytes[k+1]), 'h12);
            chk("b_gap", vcyc[k+1] - fall_q[f], 2);
            chk("b_done_after_2nd", done_cyc - fall_q[f+1], 1);
        end
        chk("b_done_cnt", done_cnt - nd, 1);

        // Timeout: busy never rises
        uart_dead = 1'b1; k = vbytes.size(); nd = done_cnt; ne = err_cnt;
        req_a(8'h3C);
        wait_idle();
        chk("to_err_cnt", err_cnt - ne, 1);
        chk("to_no_done", done_cnt - nd, 0);
        if (vbytes.size() > k) chk("to_delay", err_cyc - vcyc[k], TO);
        uart_dead = 1'b0; nd = done_cnt;
        req_a(8'h5A);
        wait_idle();
        chk("to_recover_done", done_cnt - nd, 1);
        chk("to_recover_byte", int'(vbytes[vbytes.size()-1]), 'h5A);

        // Grant held off by tx_busy
        force_busy = 1'b1; a_data = 8'h77; a_req = 1'b1; k = acks.size();
        repeat (5) tick();
        chk("busy_hold_no_ack", acks.size() - k, 0);
        force_busy = 1'b0; f = cyc;
        for (int i = 0; i < 10 && !a_ack; i++) tick();
        a_req = 1'b0;
        chk("busy_release_ack", cyc - f, 1);
        wait_idle();

        // Reset in WAIT_LO of a B frame, then restart from the low byte
        req_b(16'h1234);
        for (int i = 0; i < 50 && !uart_busy; i++) tick();
        chk("rst_mid_in_wait_lo", int'(uart_busy), 1);
        b_req = 1'b1; k = vbytes.size(); nd = done_cnt;
        tick();
        RST = 1'b1;
        tick();
        chk("rstmid_outputs", int'({a_ack, b_ack, tx_data_valid, sched_busy, frame_done, err_timeout}), 0);
        chk("rstmid_p_data", int'(tx_p_data), 0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 20 && !b_ack; i++) tick();
        b_req = 1'b0;
        wait_idle();
        chk("rstmid_nbytes", vbytes.size() - k, 2);
        if (vbytes.size() == k + 2) begin
            chk("rstmid_lo", int'(vbytes[k]), 'h34);
            chk("rstmid_hi", int'(vbytes[k+1]), 'h12);
        end
        chk("rstmid_done", done_cnt - nd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, need completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
